mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single-port 1K-word memory between `NUM_REQ` requesters. Each requester presents read/write commands with a req/gnt handshake. The arbiter registers the winning command onto the memory's `en`/`wr_rd`/`addr`/`wr_data` inputs and routes the returning `rd_data` back to the issuing requester with a per-requester valid strobe. It sits between the requester blocks and the memory instance, and is the only driver of the memory's command inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `BURST_MAX`, 4: maximum consecutive grants to one owner while another requester waits, legal range 1..15.
- `ADDR_WIDTH` and `DATA_WIDTH` come from `params.sv` (10 and 32).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_i` in NUM_REQ: request per requester; must be held until its `gnt_o` bit is seen high.
- `wr_rd_i` in NUM_REQ: per requester, 1 = write, 0 = read.
- `addr_i` in NUM_REQ*ADDR_WIDTH: packed per-requester address; requester k uses slice k.
- `wr_data_i` in NUM_REQ*DATA_WIDTH: packed per-requester write data.
- `gnt_o` out NUM_REQ: one-hot, combinational; command accepted this cycle.
- `rvalid_o` out NUM_REQ: one-hot read-data strobe.
- `rdata_o` out DATA_WIDTH: read data, shared by all requesters, qualified by `rvalid_o`.
- `mem_en` out 1, `mem_wr_rd` out 1, `mem_addr` out ADDR_WIDTH, `mem_wr_data` out DATA_WIDTH: registered command to the memory.
- `mem_rd_data` in DATA_WIDTH: memory read data, registered in the memory.

## Operation
- Ownership FSM has two states:
  - IDLE: no owner.
  - OWN(k, cnt): requester k owns the arbiter; `cnt` counts its consecutive grants.
- In IDLE, any requests → grant the first requesting index at or after `rr_ptr` (round-robin) → OWN(winner, 1).
- In OWN(k, cnt):
  - `req_i[k]` high and (cnt < BURST_MAX or no other req) → grant k; cnt saturates at BURST_MAX.
  - `req_i[k]` high, cnt == BURST_MAX, and another req pending → grant the next requester round-robin after k → OWN(new, 1).
  - `req_i[k]` low and other reqs pending → grant round-robin after k → OWN(new, 1).
  - No reqs at all → IDLE.
- `rr_ptr` ← (winner+1) mod NUM_REQ on every ownership change.
- At most one grant per cycle. No grant is issued without a matching `req_i` bit.
- Writes complete silently: no acknowledge beyond `gnt_o`.
- Reads return on `rdata_o` with `rvalid_o[owner]` set.
- Reset values:
  - `gnt_o` = 0, `rvalid_o` = 0, `rdata_o` = 0.
  - `mem_en` = 0, `mem_wr_rd` = 0, `mem_addr` = 0, `mem_wr_data` = 0.
  - FSM = IDLE, `rr_ptr` = 0, in-flight tag cleared.
- Reset mid-operation: any in-flight read is dropped, and no `rvalid_o` follows reset release.

## Timing
- Cycle N: `gnt_o[w]` = 1, and the command is captured into the issue register at the end of N.
- Cycle N+1: `mem_en` = 1, and `mem_wr_rd`/`mem_addr`/`mem_wr_data` = the captured command. A tag {w, is_read} is pipelined alongside.
- Cycle N+2, reads only: `rvalid_o[w]` = 1 and `rdata_o` = `mem_rd_data`. Read latency from grant is 2 cycles.
- Throughput is one command per cycle, back-to-back across any requesters.
- In a cycle with no grant, `mem_en` is 0 in N+1. `mem_addr`/`mem_wr_data` hold their previous values.
- Read-after-write to the same address, issued in consecutive cycles, returns the new data, because memory commands are strictly in order.
- `rdata_o` holds its last value when `rvalid_o` = 0.

## Structure
- `mem_arb_pkg`:
  - `arb_state_e` {IDLE, OWN}
  - `req_id_t` (2 bits)
  - `tag_t` {req_id_t id; logic is_read}
  - `BURST_CNT_W` = 4
- Sub-module `mem_arb_rr_pick`: combinational round-robin picker. Inputs are req vector and start index; outputs are one-hot grant and index. Used for both the IDLE and handoff cases.

## Test plan
- Reset: with `rst` = 1, all outputs are 0. Release reset, then req0 writes 0xDEADBEEF to addr 5 → `gnt_o` = 01 in N, `mem_en`/`mem_wr_rd` = 1 with addr 5 in N+1.
- Read latency: req1 reads addr 5 after the write above → `gnt_o` = 10 in N; `rvalid_o` = 10 with `rdata_o` = 0xDEADBEEF in N+2 only.
- Burst limit (BURST_MAX = 4): req0 and req1 both held high continuously → grants 0,0,0,0,1,1,1,1,0…
- Idle handoff: req1 alone for 2 cycles, then req0 alone → grants 1,1,0 with no gap cycle; FSM never enters IDLE.
- Back-to-back RAW: req0 writes 0x12345678 to addr 1023, then reads addr 1023 next cycle → `rvalid_o` = 01 with 0x12345678, 2 cycles after the read grant.
- Reset mid-read: assert `rst` in cycle N+1 of a read → `rvalid_o` stays 0 through and after reset, `mem_en` drops to 0 immediately, FSM = IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and widths for the memory arbiter slice.
// Contents: ownership state, requester id, read tag, burst counter width,
//           round-robin successor helper.
package mem_arb_pkg;

   localparam int ADDR_WIDTH  = 10;
   localparam int DATA_WIDTH  = 32;
   localparam int BURST_CNT_W = 4;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

   typedef logic [1:0]             req_id_t;
   typedef logic [BURST_CNT_W-1:0] cnt_t;

   typedef struct packed {
      req_id_t id;
      logic    is_read;
   } tag_t;

   // Next index round-robin, wrapping at n (n need not be a power of two).
   function automatic req_id_t rr_next(input req_id_t id, input int n);
      if (int'(id) >= n - 1) return '0;
      else                   return id + req_id_t'(1);
   endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Purpose : combinational round-robin picker, first requester at or after start.
// Latency : 0 cycles (pure combinational).
// Ports   : req (request vector), start (search origin) -> gnt (one-hot), idx.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
)(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            start,
   output logic [NUM_REQ-1:0] gnt,
   output req_id_t            idx
);

   logic found;
   int   pos;

   // Walk offsets from start; the inner loop keeps every vector index constant.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = int'(start) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == pos)) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               idx    = req_id_t'(j);
            end
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port memory among NUM_REQ requesters,
//           with a per-owner burst limit of BURST_MAX grants while others wait.
// Latency : grant in N, memory command in N+1, read data + rvalid in N+2.
// Backpr. : a requester holds req until its gnt bit; one command accepted per cycle.
// Ports   : req/wr_rd/addr/wr_data per requester in; gnt/rvalid/rdata out;
//           mem_en/mem_wr_rd/mem_addr/mem_wr_data to memory, mem_rd_data back.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int BURST_MAX = 4
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            wr_rd_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          mem_en,
   output logic                          mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wr_data,
   input  logic [DATA_WIDTH-1:0]         mem_rd_data
);

   localparam cnt_t BMAX = cnt_t'(BURST_MAX);

   arb_state_e state_q, state_d;
   req_id_t    owner_q, owner_d;
   req_id_t    rr_q, rr_d;
   cnt_t       cnt_q, cnt_d;

   logic [NUM_REQ-1:0] own_bit, others, pick_req, pick_gnt, gnt_c;
   req_id_t            pick_idx;

   logic                  sel_wr;
   req_id_t               sel_id;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   tag_t                  tag1_q, tag2_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // In OWN, rr_q already equals owner+1, so masking the owner and searching
   // from rr_q yields "next requester after k" for the handoff case.
   mem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (pick_req),
      .start (rr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      own_bit = '0;
      for (int i = 0; i < NUM_REQ; i++) own_bit[i] = (owner_q == req_id_t'(i));
      others   = req_i & ~own_bit;
      pick_req = (state_q == OWN) ? others : req_i;

      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      gnt_c   = '0;

      case (state_q)
         IDLE: begin
            if (|req_i) begin
               gnt_c   = pick_gnt;
               state_d = OWN;
               owner_d = pick_idx;
               cnt_d   = cnt_t'(1);
               rr_d    = rr_next(pick_idx, NUM_REQ);
            end
         end
         OWN: begin
            if (|(req_i & own_bit) && ((cnt_q < BMAX) || (others == '0))) begin
               gnt_c = own_bit;
               if (cnt_q < BMAX) cnt_d = cnt_q + cnt_t'(1);
            end else if (others != '0) begin
               gnt_c   = pick_gnt;
               owner_d = pick_idx;
               cnt_d   = cnt_t'(1);
               rr_d    = rr_next(pick_idx, NUM_REQ);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant is held off while reset is asserted so the interface reads all-zero.
   assign gnt_o = rst ? '0 : gnt_c;

   always_comb begin
      sel_wr   = 1'b0;
      sel_id   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) begin
            sel_wr   = wr_rd_i[i];
            sel_id   = req_id_t'(i);
            sel_addr = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Issue register plus two-stage read tag; reset drops any in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en      <= 1'b0;
         mem_wr_rd   <= 1'b0;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         tag1_q      <= '0;
         tag2_q      <= '0;
         rdata_q     <= '0;
      end else begin
         mem_en         <= |gnt_c;
         tag1_q.id      <= sel_id;
         tag1_q.is_read <= (|gnt_c) && !sel_wr;
         tag2_q         <= tag1_q;
         if (|gnt_c) begin
            mem_wr_rd   <= sel_wr;
            mem_addr    <= sel_addr;
            mem_wr_data <= sel_data;
         end
         if (tag2_q.is_read) rdata_q <= mem_rd_data;
      end
   end

   // Memory data lands in N+2, so it is forwarded straight through and then held.
   always_comb begin
      rvalid_o = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rvalid_o[i] = tag2_q.is_read && (tag2_q.id == req_id_t'(i));
   end

   assign rdata_o = tag2_q.is_read ? mem_rd_data : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int NR = 2;
   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_i = '0;
   logic [NR-1:0]     wr_rd_i = '0;
   logic [NR*AW-1:0]  addr_i = '0;
   logic [NR*DW-1:0]  wr_data_i = '0;
   logic [NR-1:0]     gnt_o, rvalid_o;
   logic [DW-1:0]     rdata_o;
   logic              mem_en, mem_wr_rd;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wr_data;
   logic [DW-1:0]     mem_rd_data = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mem [1024];

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(NR), .BURST_MAX(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .wr_rd_i     (wr_rd_i),
      .addr_i      (addr_i),
      .wr_data_i   (wr_data_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_en      (mem_en),
      .mem_wr_rd   (mem_wr_rd),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   // Single-port memory model with registered read data.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr_rd) mem[mem_addr] <= mem_wr_data;
         else           mem_rd_data   <= mem[mem_addr];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_i[k]              = 1'b1;
      wr_rd_i[k]            = wr;
      addr_i[k*AW +: AW]    = a;
      wr_data_i[k*DW +: DW] = d;
   endtask

   task automatic idle(input int n);
      req_i = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
      n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL reset_rvalid got %b want 00", rvalid_o); end
      n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
      n_cmp++; if ({mem_en, mem_wr_rd} !== 2'b00) begin n_err++; $display("FAIL reset_mem_ctl got %b want 00", {mem_en, mem_wr_rd}); end
      n_cmp++; if (mem_addr !== 10'h0 || mem_wr_data !== 32'h0) begin n_err++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wr_data); end
      step();
      rst = 1'b0;
      drive(0, 1'b1, 10'd5, 32'hDEADBEEF);
      #1;
      n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL first_write_gnt got %b want 01", gnt_o); end
      step();
      req_i = '0;
      #1;
      n_cmp++; if (mem_en !== 1'b1 || mem_wr_rd !== 1'b1) begin n_err++; $display("FAIL first_write_cmd got en=%b wr=%b want 1/1", mem_en, mem_wr_rd); end
      n_cmp++; if (mem_addr !== 10'd5 || mem_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL first_write_bus got %0d/%h want 5/deadbeef", mem_addr, mem_wr_data); end
      idle(2);
   endtask

   task automatic test_read_latency();
      drive(1, 1'b0, 10'd5, 32'h0);
      #1;
      n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL rd_gnt got %b want 10", gnt_o); end
      step();
      req_i = '0;
      #1;
      n_cmp++; if (mem_en !== 1'b1 || mem_wr_rd !== 1'b0 || mem_addr !== 10'd5) begin n_err++; $display("FAIL rd_cmd got en=%b wr=%b a=%0d want 1/0/5", mem_en, mem_wr_rd, mem_addr); end
      n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL rd_early_rvalid got %b want 00", rvalid_o); end
      step();
      n_cmp++; if (rvalid_o !== 2'b10 || rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %b/%h want 10/deadbeef", rvalid_o, rdata_o); end
      step();
      n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL rd_late_rvalid got %b want 00", rvalid_o); end
      n_cmp++; if (rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold got %h want deadbeef", rdata_o); end
      idle(2);
   endtask

   task automatic test_burst();
      logic [NR-1:0] exp_seq [9];
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      drive(0, 1'b1, 10'd100, 32'hA0A0A0A0);
      drive(1, 1'b1, 10'd101, 32'hB1B1B1B1);
      for (int i = 0; i < 9; i++) begin
         #1;
         n_cmp++; if (gnt_o !== exp_seq[i]) begin n_err++; $display("FAIL burst_gnt[%0d] got %b want %b", i, gnt_o, exp_seq[i]); end
         step();
      end
      idle(2);
   endtask

   task automatic test_idle_handoff();
      logic [NR-1:0] exp_seq [3];
      exp_seq = '{2'b10, 2'b10, 2'b01};
      for (int i = 0; i < 3; i++) begin
         req_i = '0;
         if (i < 2) drive(1, 1'b1, 10'd200, 32'h11111111);
         else       drive(0, 1'b1, 10'd201, 32'h22222222);
         #1;
         n_cmp++; if (gnt_o !== exp_seq[i]) begin n_err++; $display("FAIL handoff_gnt[%0d] got %b want %b", i, gnt_o, exp_seq[i]); end
         if (i > 0) begin
            n_cmp++; if (dut.state_q !== OWN) begin n_err++; $display("FAIL handoff_state[%0d] got %0d want OWN", i, dut.state_q); end
         end
         step();
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      drive(0, 1'b1, 10'd1023, 32'h12345678);
      #1;
      n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL raw_wr_gnt got %b want 01", gnt_o); end
      step();
      drive(0, 1'b0, 10'd1023, 32'h0);
      #1;
      n_cmp++; if (gnt_o !== 2'b01) begin n_err++; $display("FAIL raw_rd_gnt got %b want 01", gnt_o); end
      step();
      req_i = '0;
      #1;
      n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL raw_early_rvalid got %b want 00", rvalid_o); end
      step();
      n_cmp++; if (rvalid_o !== 2'b01 || rdata_o !== 32'h12345678) begin n_err++; $display("FAIL raw_data got %b/%h want 01/12345678", rvalid_o, rdata_o); end
      idle(2);
   endtask

   task automatic test_reset_mid_read();
      drive(1, 1'b0, 10'd5, 32'h0);
      #1;
      n_cmp++; if (gnt_o !== 2'b10) begin n_err++; $display("FAIL rmr_gnt got %b want 10", gnt_o); end
      step();
      req_i = '0;
      rst = 1'b1;
      #1;
      n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rmr_mem_en got %b want 0", mem_en); end
      n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rmr_state got %0d want IDLE", dut.state_q); end
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if (rvalid_o !== 2'b00) begin n_err++; $display("FAIL rmr_rvalid_in_rst[%0d] got %b want 00", i, rvalid_o); end
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (rvalid_o !== 2'b00 || mem_en !== 1'b0) begin n_err++; $display("FAIL rmr_after[%0d] got rvalid=%b en=%b want 00/0", i, rvalid_o, mem_en); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      test_reset();
      test_read_latency();
      test_burst();
      test_idle_handoff();
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
